// File: rtl/lsu_pkg.sv
// Shared CPU constants for the load/store unit: access-type encodings, LSU FSM states
// and small byte-lane helpers used by the LSU datapath.
package lsu_pkg;

  localparam int unsigned TimeoutDefault = 16;

  localparam logic [2:0] DmWord  = 3'b000;
  localparam logic [2:0] DmHalfS = 3'b001;
  localparam logic [2:0] DmHalfU = 3'b010;
  localparam logic [2:0] DmByteS = 3'b011;
  localparam logic [2:0] DmByteU = 3'b100;

  typedef enum logic [1:0] {StIdle, StBus, StResp} lsu_state_e;

  function automatic logic is_half(input logic [2:0] t);
    return (t == DmHalfS) || (t == DmHalfU);
  endfunction

  function automatic logic is_byte(input logic [2:0] t);
    return (t == DmByteS) || (t == DmByteU);
  endfunction

  // Unknown access codes behave as word accesses.
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    if (is_byte(t)) return 1'b0;
    if (is_half(t)) return a[0];
    return a != 2'b00;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
    if (is_byte(t)) return 4'b0001 << a;
    if (is_half(t)) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] t, input logic [31:0] d);
    if (is_byte(t)) return {4{d[7:0]}};
    if (is_half(t)) return {2{d[15:0]}};
    return d;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide memory request/acknowledge bus between the LSU (master) and data memory (slave).
interface lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_ext.sv
// Load lane selection and sign/zero extension of a raw memory word.
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  DMType,
  input  logic [1:0]  addr,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = bus_rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (DMType)
      DmHalfS: rdata = {{16{h[15]}}, h};
      DmHalfU: rdata = {16'h0000, h};
      DmByteS: rdata = {{24{b[7]}}, b};
      DmByteU: rdata = {24'h000000, b};
      default: rdata = bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one bus access per instruction, stalls the pipe until done,
// aborts on misaligned addresses or when the bus fails to acknowledge within TIMEOUT cycles.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DMType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  lsu_if.master       bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  lsu_state_e      state_q;
  logic [CntW-1:0] wait_q;
  logic [2:0]      dmtype_q;
  logic [1:0]      addr_lo_q;
  logic            access;
  logic [31:0]     ext_rdata;

  assign access = mem_valid & (MemRead | MemWrite);
  assign stall  = access & ~done;

  lsu_ext u_ext (
    .DMType    (dmtype_q),
    .addr      (addr_lo_q),
    .bus_rdata (bus.bus_rdata),
    .rdata     (ext_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      wait_q        <= '0;
      dmtype_q      <= DmWord;
      addr_lo_q     <= 2'b00;
      rdata         <= '0;
      done          <= 1'b0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (access) begin
            dmtype_q  <= DMType;
            addr_lo_q <= addr[1:0];
            wait_q    <= '0;
            if (misaligned(DMType, addr[1:0])) begin
              state_q  <= StResp;
              done     <= 1'b1;
              misalign <= 1'b1;
              rdata    <= '0;
            end else begin
              state_q       <= StBus;
              bus.bus_req   <= 1'b1;
              // A simultaneous read and write request is treated as a load.
              bus.bus_we    <= MemWrite & ~MemRead;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_be    <= byte_en(DMType, addr[1:0]);
              bus.bus_wdata <= lane_wdata(DMType, wdata);
            end
          end
        end
        StBus: begin
          if (bus.bus_ack) begin
            state_q     <= StResp;
            bus.bus_req <= 1'b0;
            done        <= 1'b1;
            rdata       <= bus.bus_we ? 32'h0 : ext_rdata;
          end else begin
            wait_q <= wait_q + 1'b1;
            if (wait_q == CntW'(TIMEOUT - 1)) begin
              state_q     <= StResp;
              bus.bus_req <= 1'b0;
              done        <= 1'b1;
              bus_err     <= 1'b1;
              rdata       <= '0;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          wait_q  <= '0;
          rdata   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles bus_req is held without bus_ack before the access aborts.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 mem_valid  in  1  MEM-stage instruction present.
REQ-005 MemRead  in  1  load (WDSel==2'b01 from decode).
REQ-006 MemWrite  in  1  store.
REQ-007 DMType  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes treated as word.
REQ-008 addr  in  32  byte address (ALU result).
REQ-009 wdata  in  32  store data, right-aligned (rs2).
REQ-010 rdata  out  32  extended load result, valid when done=1 and MemRead.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 stall  out  1  hold PC/IF/ID/EX/MEM registers.
REQ-013 misalign  out  1  with done: access aborted for misaligned address.
REQ-014 bus_err  out  1  with done: access aborted for timeout.
REQ-015 bus_req  out  1  memory request; bus_we, bus_addr[31:0] (word-aligned, addr[1:0]=00), bus_be[3:0] and bus_wdata[31:0] must be stable while bus_req=1.
REQ-016 bus_ack  in  1  memory response; bus_rdata[31:0] sampled in the bus_ack cycle.

Function
REQ-017 FSM states: IDLE, BUS, RESP.
REQ-018 IDLE -> BUS when mem_valid & (MemRead | MemWrite) & aligned; the request fields register on that edge.
REQ-019 IDLE -> RESP with misalign=1 and no bus_req when the address is misaligned (half: addr[0]=1; word: addr[1:0]!=0).
REQ-020 BUS: bus_req=1; bus_ack -> RESP.
REQ-021 BUS: a wait counter increments each cycle without bus_ack; counter reaching TIMEOUT -> RESP with bus_err=1.
REQ-022 RESP: done=1 for exactly one cycle, then -> IDLE.
REQ-023 Aligned access latency: request cycle to done = 2 + ack wait cycles (zero-wait ack gives done on cycle 2).
REQ-024 stall = mem_valid & (MemRead | MemWrite) & ~done; combinational.
REQ-025 In IDLE, a new access is accepted only on the cycle after done; re-acceptance in the RESP cycle is prohibited.
REQ-026 bus_be: word 1111; half 0011 or 1100 by addr[1]; byte 0001 << addr[1:0].
REQ-027 bus_wdata: byte/half data replicated into every lane (byte x4, half x2).
REQ-028 Load: select the lane by registered addr[1:0]; sign-extend for 001/011, zero-extend for 010/100.
REQ-029 Stores drive rdata=0.
REQ-030 misalign and bus_err are 0 whenever done=0.
REQ-031 MemRead & MemWrite both high is illegal: treat as a load.
REQ-032 bus_ack outside BUS is ignored.

Reset
REQ-033 rst=1 forces IDLE, wait counter=0, and all outputs to 0 (rdata, done, misalign, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata) regardless of the clock.
REQ-034 rst asserted during BUS drops bus_req immediately with no done pulse; the outstanding ack is ignored.

Structure
REQ-035 DMType encodings, FSM state enum and the default TIMEOUT go in the shared CPU package beside the decode constants.
REQ-036 Load alignment/extension is a separate combinational sub-module, lsu_ext (inputs DMType, addr[1:0], bus_rdata; output rdata).

Verification
REQ-037 lw at 0x100, ack on the first BUS cycle, bus_rdata=0xDEADBEEF -> bus_be=1111, done on cycle 2, rdata=0xDEADBEEF, stall high for 2 cycles.
REQ-038 lb (011) at 0x103, bus_rdata=0x80112233 -> bus_be=1000, rdata=0xFFFFFF80; the same access as lbu (100) -> rdata=0x00000080.
REQ-039 sh at 0x202 with wdata=0x0000ABCD -> bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD.
REQ-040 lw at 0x101 -> no bus_req, done and misalign on cycle 1.
REQ-041 sw with bus_ack never asserted, TIMEOUT=16 -> bus_req high 16 cycles, then done with bus_err=1, then IDLE.
REQ-042 rst pulsed on the third BUS cycle, then ack -> bus_req low asynchronously, no done pulse, state IDLE.
